// File: rtl/mem_block_arbiter.sv
// Arbiter between the I-cache refill port and the D-cache refill/writeback port
// for the single-port block data memory. Memory latency is modelled by a programmable count.
module mem_block_arbiter #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned BLOCK_WIDTH   = 128,
  parameter int unsigned LATENCY       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     icache_req,
  input  logic [ADDRESS_WIDTH-1:0] icache_addr,
  output logic                     icache_ready,
  output logic [BLOCK_WIDTH-1:0]   icache_rdata,
  input  logic                     dcache_req,
  input  logic                     dcache_we,
  input  logic [ADDRESS_WIDTH-1:0] dcache_addr,
  input  logic [BLOCK_WIDTH-1:0]   dcache_wdata,
  output logic                     dcache_ready,
  output logic [BLOCK_WIDTH-1:0]   dcache_rdata,
  output logic                     mem_wr_en,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [BLOCK_WIDTH-1:0]   mem_wdata,
  input  logic [BLOCK_WIDTH-1:0]   mem_rdata,
  output logic                     busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;
  localparam logic [7:0] COUNT_INIT = 8'(LATENCY - 1);
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = {{(ADDRESS_WIDTH-4){1'b1}}, 4'b0000};

  state_e                   state_q, state_d;
  logic [7:0]               count_q, count_d;
  logic                     grant_q, grant_d;
  logic                     last_grant_q, last_grant_d;
  logic                     we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [BLOCK_WIDTH-1:0]   wdata_q, wdata_d;
  logic [BLOCK_WIDTH-1:0]   irdata_q, irdata_d;
  logic [BLOCK_WIDTH-1:0]   drdata_q, drdata_d;
  logic                     pick_d;
  logic                     final_cycle;

  assign final_cycle = (state_q == S_BUSY) && (count_q == 8'd0);

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    irdata_d     = irdata_q;
    drdata_d     = drdata_q;
    pick_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (icache_req || dcache_req) begin
          // D wins when alone, or when both request and I was served last
          pick_d  = dcache_req && (!icache_req || (last_grant_q == GRANT_I));
          grant_d = pick_d ? GRANT_D : GRANT_I;
          we_d    = pick_d && dcache_we;
          addr_d  = (pick_d ? dcache_addr : icache_addr) & ALIGN_MASK;
          if (pick_d) begin
            wdata_d = dcache_wdata;
          end
          count_d = COUNT_INIT;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (count_q != 8'd0) begin
          count_d = count_q - 8'd1;
        end else begin
          state_d = S_RESP;
          if (!we_q) begin
            if (grant_q == GRANT_D) begin
              drdata_d = mem_rdata;
            end else begin
              irdata_d = mem_rdata;
            end
          end
        end
      end
      S_RESP: begin
        last_grant_d = grant_q;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      grant_q      <= GRANT_I;
      last_grant_q <= GRANT_D;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      irdata_q     <= '0;
      drdata_q     <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      irdata_q     <= irdata_d;
      drdata_q     <= drdata_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign mem_wr_en    = final_cycle && we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign icache_ready = (state_q == S_RESP) && (grant_q == GRANT_I);
  assign dcache_ready = (state_q == S_RESP) && (grant_q == GRANT_D);
  assign icache_rdata = irdata_q;
  assign dcache_rdata = drdata_q;

endmodule

// File: tb/tb_mem_block_arbiter.sv
// Scoreboard bench for mem_block_arbiter: LATENCY=4 instance checked by a queue-driven
// monitor, plus a LATENCY=1 instance checked with directed samples.
module tb_mem_block_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned BW = 128;
  localparam logic [BW-1:0] LINE_100 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [BW-1:0] WD       = 128'hDEADBEEF_CAFEF00D_12345678_0BADF00D;
  localparam logic [BW-1:0] WD2      = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic          i_req = 0, d_req = 0, d_we = 0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [BW-1:0] d_wdata = '0;
  logic          i_ready, d_ready, wr_en, busy;
  logic [BW-1:0] i_rdata, d_rdata, m_wdata, m_rdata;
  logic [AW-1:0] m_addr;

  logic          i_req1 = 0;
  logic [AW-1:0] i_addr1 = '0;
  logic          d_req1 = 0, d_we1 = 0;
  logic [AW-1:0] d_addr1 = '0;
  logic [BW-1:0] d_wdata1 = '0;
  logic          i_ready1, d_ready1, wr_en1, busy1;
  logic [BW-1:0] i_rdata1, d_rdata1, m_wdata1, m_rdata1;
  logic [AW-1:0] m_addr1;

  logic [BW-1:0] mem  [0:63];
  logic [BW-1:0] mem1 [0:63];

  function automatic logic [BW-1:0] init_line(input int unsigned i);
    if (i == 16) return LINE_100;
    return {32'h00C00000 | i, 32'h11110000 | i, 32'h22220000 | i, 32'h33330000 | i};
  endfunction

  assign m_rdata  = mem[m_addr[9:4]];
  assign m_rdata1 = mem1[m_addr1[9:4]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) begin
        mem[i]  <= init_line(i);
        mem1[i] <= init_line(i);
      end
    end else begin
      if (wr_en)  mem[m_addr[9:4]]   <= m_wdata;
      if (wr_en1) mem1[m_addr1[9:4]] <= m_wdata1;
    end
  end

  mem_block_arbiter #(.ADDRESS_WIDTH(AW), .BLOCK_WIDTH(BW), .LATENCY(4)) dut (
    .clk(clk), .rst(rst),
    .icache_req(i_req), .icache_addr(i_addr), .icache_ready(i_ready), .icache_rdata(i_rdata),
    .dcache_req(d_req), .dcache_we(d_we), .dcache_addr(d_addr), .dcache_wdata(d_wdata),
    .dcache_ready(d_ready), .dcache_rdata(d_rdata),
    .mem_wr_en(wr_en), .mem_addr(m_addr), .mem_wdata(m_wdata), .mem_rdata(m_rdata),
    .busy(busy)
  );

  mem_block_arbiter #(.ADDRESS_WIDTH(AW), .BLOCK_WIDTH(BW), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .icache_req(i_req1), .icache_addr(i_addr1), .icache_ready(i_ready1), .icache_rdata(i_rdata1),
    .dcache_req(d_req1), .dcache_we(d_we1), .dcache_addr(d_addr1), .dcache_wdata(d_wdata1),
    .dcache_ready(d_ready1), .dcache_rdata(d_rdata1),
    .mem_wr_en(wr_en1), .mem_addr(m_addr1), .mem_wdata(m_wdata1), .mem_rdata(m_rdata1),
    .busy(busy1)
  );

  typedef struct {
    bit            is_d;
    bit            we;
    logic [AW-1:0] addr;
    logic [BW-1:0] data;
    int unsigned   cyc;
  } exp_t;

  exp_t q[$];
  logic [BW-1:0] exp_i = '0;
  logic [BW-1:0] exp_d = '0;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input bit is_d, input bit we, input logic [AW-1:0] addr,
                      input logic [BW-1:0] data, input int unsigned offset);
    exp_t e;
    e.is_d = is_d;
    e.we   = we;
    e.addr = addr;
    e.data = data;
    e.cyc  = cyc + offset;
    q.push_back(e);
  endtask

  // Holds the request until n ready pulses have been seen, then drops it.
  task automatic wait_ready(input bit is_d, input int n);
    int seen = 0;
    int t = 0;
    while (seen < n && t < 200) begin
      @(negedge clk);
      t++;
      if (is_d ? d_ready : i_ready) seen++;
    end
    chk(is_d ? "d_ready_timeout" : "i_ready_timeout", seen, n);
    @(posedge clk);
    #1;
    if (is_d) d_req = 1'b0;
    else      i_req = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t it;
    if (!rst && !preload) begin
      if (busy) begin
        if (q.size() == 0) begin
          chk("busy_without_request", busy, 0);
        end else begin
          chk("mem_addr", m_addr, q[0].addr);
          chk("mem_wr_en", wr_en, (q[0].we && (cyc == q[0].cyc - 1)));
          if (wr_en) chk("mem_wdata", m_wdata, q[0].data);
        end
      end else begin
        chk("mem_wr_en_idle", wr_en, 0);
      end
      if (i_ready || d_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_ready", {i_ready, d_ready}, 0);
        end else begin
          it = q.pop_front();
          chk("ready_port", {i_ready, d_ready}, it.is_d ? 2'b01 : 2'b10);
          chk("ready_cycle", cyc, it.cyc);
          if (!it.we) begin
            if (it.is_d) exp_d = it.data;
            else         exp_i = it.data;
          end
          chk("icache_rdata", i_rdata, exp_i);
          chk("dcache_rdata", d_rdata, exp_d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    step(2);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_mem_addr", m_addr, 0);
    chk("rst_mem_wdata", m_wdata, 0);
    chk("rst_ready", {i_ready, d_ready}, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst1_outputs", {i_ready1, d_ready1, wr_en1, busy1}, 0);
    chk("rst1_rdata", i_rdata1 | d_rdata1, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    preload = 1'b0;
    step(2);

    // I-side read of an unaligned address
    i_addr = 32'h0000_0107;
    push(1'b0, 1'b0, 32'h100, LINE_100, 5);
    i_req = 1'b1;
    wait_ready(1'b0, 1);
    step(2);

    // D-side writeback, then read it back
    d_addr = 32'h200; d_we = 1'b1; d_wdata = WD;
    push(1'b1, 1'b1, 32'h200, WD, 5);
    d_req = 1'b1;
    wait_ready(1'b1, 1);
    step(1);
    d_we = 1'b0;
    push(1'b1, 1'b0, 32'h200, WD, 5);
    d_req = 1'b1;
    wait_ready(1'b1, 1);
    step(2);

    // Reset during BUSY cycle 2 of a write aborts it
    d_addr = 32'h300; d_we = 1'b1; d_wdata = WD2;
    push(1'b1, 1'b1, 32'h300, WD2, 5);
    d_req = 1'b1;
    step(2);
    #2;
    rst = 1'b1;
    q.delete();
    exp_i = '0;
    exp_d = '0;
    d_req = 1'b0;
    d_we  = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_wr_en", wr_en, 0);
    chk("arst_mem_addr", m_addr, 0);
    chk("arst_mem_wdata", m_wdata, 0);
    chk("arst_ready", {i_ready, d_ready}, 0);
    chk("arst_i_rdata", i_rdata, 0);
    chk("arst_d_rdata", d_rdata, 0);
    step(2);
    rst = 1'b0;
    step(1);
    chk("line_300_kept", mem[48], init_line(48));
    step(1);

    // Simultaneous requests held across completions: order I, D, I, D
    i_addr = 32'h110; d_addr = 32'h120; d_we = 1'b0;
    push(1'b0, 1'b0, 32'h110, init_line(17), 5);
    push(1'b1, 1'b0, 32'h120, init_line(18), 11);
    push(1'b0, 1'b0, 32'h110, init_line(17), 17);
    push(1'b1, 1'b0, 32'h120, init_line(18), 23);
    i_req = 1'b1;
    d_req = 1'b1;
    fork
      wait_ready(1'b0, 2);
      wait_ready(1'b1, 2);
    join
    step(2);

    // Request dropped right after grant still completes, no regrant
    d_addr = 32'h130; d_we = 1'b0;
    push(1'b1, 1'b0, 32'h130, init_line(19), 5);
    d_req = 1'b1;
    step(1);
    d_req = 1'b0;
    wait_ready(1'b1, 1);
    step(8);
    chk("no_regrant_busy", busy, 0);
    chk("queue_drained", q.size(), 0);

    // LATENCY=1 read
    i_addr1 = 32'h47;
    i_req1 = 1'b1;
    @(negedge clk);
    chk("l1_ready_c0", i_ready1, 0);
    @(negedge clk);
    chk("l1_busy_c1", busy1, 1);
    chk("l1_mem_addr", m_addr1, 32'h40);
    chk("l1_wr_en", wr_en1, 0);
    chk("l1_ready_c1", i_ready1, 0);
    @(negedge clk);
    chk("l1_ready_c2", i_ready1, 1);
    chk("l1_rdata", i_rdata1, init_line(4));
    @(posedge clk);
    #1;
    i_req1 = 1'b0;
    @(negedge clk);
    chk("l1_ready_c3", i_ready1, 0);
    chk("l1_busy_c3", busy1, 0);

    step(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_block_arbiter.md
# mem_block_arbiter

Arbitrates and sequences access to the single 128-bit-block data memory between the instruction-cache refill port and the data-cache refill/writeback port. It sits between both cache controllers and `data_mem`, drives that memory's `wr_en`, `addr` and `WriteBlockData`, and captures `ReadBlockData`. It models main-memory latency with a programmable cycle count and returns results to the requesters over a req/ready handshake.

## Interface
- ADDRESS_WIDTH, 32, byte address width
- BLOCK_WIDTH, 128, cache line / memory block width in bits (16 bytes)
- LATENCY, 4, cycles spent in BUSY per transaction; legal range 1..255
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- icache_req  in  1  I-side read request, held until icache_ready
- icache_addr  in  ADDRESS_WIDTH  I-side line address
- icache_ready  out  1  one-cycle completion pulse to I-side
- icache_rdata  out  BLOCK_WIDTH  registered line for the last completed I-side read
- dcache_req  in  1  D-side request, held until dcache_ready
- dcache_we  in  1  1 = writeback of dcache_wdata, 0 = refill read
- dcache_addr  in  ADDRESS_WIDTH  D-side line address
- dcache_wdata  in  BLOCK_WIDTH  writeback line
- dcache_ready  out  1  one-cycle completion pulse to D-side
- dcache_rdata  out  BLOCK_WIDTH  registered line for the last completed D-side read
- mem_wr_en  out  1  to data_mem wr_en
- mem_addr  out  ADDRESS_WIDTH  to data_mem addr
- mem_wdata  out  BLOCK_WIDTH  to data_mem WriteBlockData
- mem_rdata  in  BLOCK_WIDTH  from data_mem ReadBlockData (combinational read)
- busy  out  1  high in BUSY and RESP

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: if no req, stay. If exactly one req, grant it. If both, grant the port not served last (`last_grant`). On grant, latch grantee, `we` (forced 0 for I-side), aligned address (`addr & ~0xF`) and wdata. Load `count = LATENCY-1`, go to BUSY.
- BUSY: mem_addr = latched address; mem_wdata = latched wdata. Decrement count each cycle while count != 0.
- BUSY with count == 0, final cycle:
  - Write: mem_wr_en = 1 for exactly this cycle, so data_mem commits on the exiting edge.
  - Read: the grantee's rdata register captures mem_rdata on the exiting edge.
  - In both cases, go to RESP.
- RESP: assert the grantee's ready for one cycle, update `last_grant`, return to IDLE.
- A req still high in IDLE after ready is treated as a new request.
- Requester inputs are sampled only at grant. Later changes, including req dropping mid-transaction, are ignored, and the transaction still completes with ready.
- Writes never update either rdata register. Each rdata register holds its value until that port's next read completes.
- Address low 4 bits are always zeroed toward memory. No range check is done; requesters keep addresses within memory size.
- Outside the write cycle, mem_wr_en = 0. In IDLE, mem_addr and mem_wdata keep their last latched values.

## Timing
- Reset (async, immediate):
  - State IDLE, count 0, busy 0, mem_wr_en 0, mem_addr 0, mem_wdata 0.
  - Both ready 0, both rdata 0.
  - `last_grant` = D, so the first simultaneous request goes to I.
- Request seen in IDLE at cycle 0 gives BUSY in cycles 1..LATENCY and ready high in cycle LATENCY+1.
- Back-to-back grants start every LATENCY+2 cycles.
- With LATENCY=1, BUSY lasts one cycle, and that cycle is also the write/capture cycle.
- Reset asserted mid-BUSY aborts the transaction:
  - No ready is issued.
  - A write is not performed unless its wr_en edge has already occurred.
  - mem_wr_en drops asynchronously.
- A new request arriving during BUSY/RESP waits. Arbitration happens only in IDLE.

## Test plan
- I-side read, addr 0x0000_0107, LATENCY=4, memory line at 0x100 = 0x00112233_44556677_8899AABB_CCDDEEFF -> mem_addr 0x100 during BUSY; icache_ready single pulse 5 cycles after req; icache_rdata = that line; mem_wr_en never high.
- D-side writeback, addr 0x200, wdata 0xDEADBEEF_..._0BADF00D -> mem_wr_en high exactly one cycle (BUSY cycle 4); subsequent D read of 0x200 returns the written line; dcache_rdata unchanged by the write.
- I and D req asserted same cycle after reset, both held and re-requested -> grant order I, D, I, D; ready pulses spaced LATENCY+2 = 6 cycles.
- Reset asserted in BUSY cycle 2 of a D write to 0x300 -> no dcache_ready; mem_wr_en never high; line 0x300 unchanged; all outputs at reset values immediately.
- LATENCY=1 read -> ready 2 cycles after req; correct data captured.
- Requester drops req one cycle after grant -> transaction still completes and ready pulses; no second grant follows.
